// File: rtl/pc16_pkg.sv
// pc16 shared definitions: sizes, per-edge operation encoding, decode helpers.
package pc16_pkg;

  localparam int PC_WIDTH = 16;
  localparam int RS_DEPTH = 4;

  // One operation is selected per edge, in priority order.
  typedef enum logic [2:0] {
    OP_HOLD     = 3'd0,
    OP_INC      = 3'd1,
    OP_JUMP     = 3'd2,
    OP_CALL     = 3'd3,
    OP_CALL_OVF = 3'd4,
    OP_RET      = 3'd5,
    OP_RET_UFL  = 3'd6
  } pc_op_e;

  // Priority decode. A push without load never reaches the stack: it falls
  // through to the return/increment/hold cases as if push were low.
  function automatic pc_op_e pc_decode(input logic load, input logic push,
                                       input logic pop,  input logic inc,
                                       input logic full, input logic empty);
    pc_op_e op;
    if (load && push)  op = full ? OP_CALL_OVF : OP_CALL;
    else if (load)     op = OP_JUMP;
    else if (pop)      op = empty ? OP_RET_UFL : OP_RET;
    else if (inc)      op = OP_INC;
    else               op = OP_HOLD;
    return op;
  endfunction

  // Conditions that raise the sticky error flag.
  function automatic logic pc_fault(input pc_op_e op, input logic load,
                                    input logic push, input logic pop);
    return (op == OP_CALL_OVF) || (op == OP_RET_UFL) ||
           ((op == OP_JUMP) && pop) || (!load && push);
  endfunction

endpackage

// File: rtl/pc16_if.sv
// Control/address bus of the program counter. The master drives the target
// and operation strobes; the slave (pc16) returns the PC and stack status.
interface pc16_if #(parameter int WIDTH = 16);

  logic [WIDTH-1:0] in;
  logic             load;
  logic             inc;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] out;
  logic             full;
  logic             empty;
  logic             err;

  modport master (output in, load, inc, push, pop,
                  input  out, full, empty, err);

  modport slave  (input  in, load, inc, push, pop,
                  output out, full, empty, err);

endinterface

// File: rtl/pc16_ret_stack.sv
// Return-address stack: register array plus depth counter. push_en/pop_en
// arrive pre-qualified, so no overflow/underflow protection is needed here.
module ret_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_en_i,
  input  logic             pop_en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      depth_q, depth_d;
  logic [AW-1:0]    top_idx;

  // Top entry sits one below the depth pointer; wraps harmlessly when empty.
  assign top_idx = depth_q[AW-1:0] - AW'(1);
  assign top_o   = mem_q[top_idx];
  assign full_o  = (depth_q == (AW+1)'(DEPTH));
  assign empty_o = (depth_q == '0);

  // Depth next state: push and pop are never asserted together.
  always_comb begin
    depth_d = depth_q;
    if (push_en_i)     depth_d = depth_q + (AW+1)'(1);
    else if (pop_en_i) depth_d = depth_q - (AW+1)'(1);
  end

  // Depth register; contents need no reset since they are unread while empty.
  always_ff @(posedge clk) begin
    if (rst) depth_q <= '0;
    else     depth_q <= depth_d;
  end

  // Entry write at the current depth pointer.
  always_ff @(posedge clk) begin
    if (push_en_i) mem_q[depth_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/pc16.sv
// 16-bit program counter with return-address stack: hold, increment, jump,
// call (jump + push return address) and return (pop), registered update.
module pc16
  import pc16_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = RS_DEPTH
) (
  input  logic   clk,
  input  logic   rst,
  pc16_if.slave  bus
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] out_inc;
  logic [WIDTH-1:0] stk_top;
  logic             stk_full, stk_empty;
  logic             push_en, pop_en;
  pc_op_e           op;

  // Wraps modulo 2^WIDTH; also the pushed return address.
  assign out_inc = out_q + WIDTH'(1);

  ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push_en_i (push_en),
    .pop_en_i  (pop_en),
    .din_i     (out_inc),
    .top_o     (stk_top),
    .full_o    (stk_full),
    .empty_o   (stk_empty)
  );

  // Operation decode and next-state for PC, error flag and stack strobes.
  always_comb begin
    out_d   = out_q;
    err_d   = err_q;
    push_en = 1'b0;
    pop_en  = 1'b0;
    op      = pc_decode(bus.load, bus.push, bus.pop, bus.inc, stk_full, stk_empty);
    case (op)
      OP_CALL:     begin out_d = bus.in; push_en = 1'b1; end
      OP_CALL_OVF: out_d = bus.in;
      OP_JUMP:     out_d = bus.in;
      OP_RET:      begin out_d = stk_top; pop_en = 1'b1; end
      OP_INC:      out_d = out_inc;
      default:     out_d = out_q;
    endcase
    if (pc_fault(op, bus.load, bus.push, bus.pop)) err_d = 1'b1;
  end

  // PC and sticky error register; reset overrides any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.full  = stk_full;
  assign bus.empty = stk_empty;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_pc16.sv
// Self-checking bench for pc16: directed vectors, a spec-level model checked
// every cycle, and literal expectations after each directed step.
module tb_pc16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc16_if #(.WIDTH(16)) bus ();

  pc16 #(.WIDTH(16), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: PC value, a list of saved return addresses, sticky error.
  logic [15:0] m_pc;
  logic [15:0] m_stk [4];
  int          m_depth;
  logic        m_err;
  bit          m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the inputs present at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_pc    <= 16'h0000;
      m_depth <= 0;
      m_err   <= 1'b0;
      m_valid <= 1'b1;
    end else if (bus.load) begin
      m_pc <= bus.in;
      if (bus.push) begin
        if (m_depth < 4) begin
          m_stk[m_depth] <= m_pc + 16'h0001;
          m_depth        <= m_depth + 1;
        end else m_err <= 1'b1;
      end else if (bus.pop) m_err <= 1'b1;
    end else begin
      if (bus.push) m_err <= 1'b1;
      if (bus.pop) begin
        if (m_depth > 0) begin
          m_pc    <= m_stk[m_depth-1];
          m_depth <= m_depth - 1;
        end else m_err <= 1'b1;
      end else if (bus.inc) m_pc <= m_pc + 16'h0001;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_out",   {16'h0, bus.out},  {16'h0, m_pc});
      chk("model_full",  {31'h0, bus.full}, {31'h0, (m_depth == 4)});
      chk("model_empty", {31'h0, bus.empty},{31'h0, (m_depth == 0)});
      chk("model_err",   {31'h0, bus.err},  {31'h0, m_err});
    end
  end

  // Apply one set of inputs for one edge; outputs are settled on return.
  task automatic cyc(input logic r, input logic [15:0] d, input logic ld,
                     input logic ic, input logic ps, input logic pp);
    rst = r; bus.in = d; bus.load = ld; bus.inc = ic; bus.push = ps; bus.pop = pp;
    @(posedge clk);
    #1;
    rst = 1'b0; bus.load = 1'b0; bus.inc = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
  endtask

  task automatic chk_st(input string name, input logic [15:0] o, input logic f,
                        input logic e, input logic er);
    chk({name, "_out"},   {16'h0, bus.out},  {16'h0, o});
    chk({name, "_full"},  {31'h0, bus.full}, {31'h0, f});
    chk({name, "_empty"}, {31'h0, bus.empty},{31'h0, e});
    chk({name, "_err"},   {31'h0, bus.err},  {31'h0, er});
  endtask

  initial begin
    bus.in = '0; bus.load = 0; bus.inc = 0; bus.push = 0; bus.pop = 0;
    @(posedge clk); #1;

    // 1: reset then three increments
    cyc(1, 16'h0, 0, 0, 0, 0);  chk_st("reset", 16'h0000, 0, 1, 0);
    repeat (3) cyc(0, 16'h0, 0, 1, 0, 0);
    chk_st("inc3", 16'h0003, 0, 1, 0);

    // 2: wrap at 0xFFFF
    cyc(0, 16'hFFFF, 1, 0, 0, 0); chk_st("ld_ffff", 16'hFFFF, 0, 1, 0);
    cyc(0, 16'h0, 0, 1, 0, 0);    chk_st("wrap", 16'h0000, 0, 1, 0);

    // 3: single call and return
    cyc(0, 16'h0010, 1, 0, 0, 0); chk_st("ld_10", 16'h0010, 0, 1, 0);
    cyc(0, 16'h0100, 1, 0, 1, 0); chk_st("call1", 16'h0100, 0, 0, 0);
    cyc(0, 16'h0, 0, 0, 0, 1);    chk_st("ret1", 16'h0011, 0, 1, 0);

    // 4: fill the stack, overflow, unwind (return addresses are each caller's PC+1)
    cyc(0, 16'h1000, 1, 0, 1, 0); chk_st("callA", 16'h1000, 0, 0, 0);
    cyc(0, 16'h2000, 1, 0, 1, 0);
    cyc(0, 16'h3000, 1, 0, 1, 0);
    cyc(0, 16'h4000, 1, 0, 1, 0); chk_st("callD", 16'h4000, 1, 0, 0);
    cyc(0, 16'h5000, 1, 0, 1, 0); chk_st("ovf", 16'h5000, 1, 0, 1);
    cyc(0, 16'h0, 0, 0, 0, 1);    chk_st("pop1", 16'h3001, 0, 0, 1);
    cyc(0, 16'h0, 0, 1, 0, 1);    chk_st("pop2", 16'h2001, 0, 0, 1);
    cyc(0, 16'h0, 0, 0, 0, 1);    chk_st("pop3", 16'h1001, 0, 0, 1);
    cyc(0, 16'h0, 0, 0, 0, 1);    chk_st("pop4", 16'h0012, 0, 1, 1);

    // 5: underflow, error is sticky until reset
    cyc(1, 16'h0, 0, 0, 0, 0);    chk_st("rst5", 16'h0000, 0, 1, 0);
    cyc(0, 16'h0, 0, 1, 0, 1);    chk_st("ufl", 16'h0000, 0, 1, 1);
    cyc(0, 16'h00AA, 1, 0, 0, 0); chk_st("sticky", 16'h00AA, 0, 1, 1);
    cyc(1, 16'h0, 0, 0, 0, 0);    chk_st("clr", 16'h0000, 0, 1, 0);

    // 6: conflicts
    cyc(0, 16'h0042, 1, 1, 0, 0); chk_st("ld_inc", 16'h0042, 0, 1, 0);
    cyc(0, 16'h0077, 1, 0, 0, 1); chk_st("ld_pop", 16'h0077, 0, 1, 1);
    cyc(1, 16'h0, 0, 0, 0, 0);
    cyc(0, 16'h0, 0, 1, 1, 0);    chk_st("push_noload", 16'h0001, 0, 1, 1);

    // 7: reset wins over a return in flight
    cyc(1, 16'h0, 0, 0, 0, 0);
    cyc(0, 16'h0200, 1, 0, 1, 0); chk_st("call7", 16'h0200, 0, 0, 0);
    cyc(1, 16'h0, 0, 0, 0, 1);    chk_st("rst_pop", 16'h0000, 0, 1, 0);

    // Hold with no strobes
    cyc(0, 16'h1234, 0, 0, 0, 0); chk_st("hold", 16'h0000, 0, 1, 0);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
